// File: rtl/quadtree_switch_allocator.sv
// ---------------------------------------------------------------------------
// quadtree_switch_allocator
//
// Single-cycle switch allocator for the quadtree router. In each cycle it
// arbitrates the multicast switch requests of five input units (NW, NE, SE,
// SW, LOCAL) against downstream credit availability.
//
// Fairness comes from two mechanisms:
//   - A round-robin pointer sets the scan order.
//   - Per-input age counters detect a starving packet. The lowest-index
//     starving input reserves its requested outputs until all of its credits
//     are available at the same time.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous, active-low reset
//   sa_request     per-input "flit waiting for switch allocation"
//   sa_port        bits [g*5+:5] = output mask requested by input g
//   credit_avail   per-output "downstream credit > 0"
//   sa_grant       per-input grant, combinational, same cycle as the request
//   st_ctrl        bits [g*5+:5] = outputs input g drives (mask if granted)
//   out_unit_en    OR of all granted masks
//   credit_decre   one-cycle credit decrement pulse (equals out_unit_en)
//   req_err        some requesting input presented an all-zero mask
//   rr_ptr         current round-robin pointer (0..DIRECTION-1)
//   starve_active  at least one input is starving
//
// Handshake: an input keeps sa_request and sa_port stable until sa_grant is
// seen high in the same cycle. Each grant consumes exactly one flit.
// ---------------------------------------------------------------------------
module quadtree_switch_allocator #(
    parameter int DIRECTION    = 5,
    parameter int STARVE_LIMIT = 15,
    parameter int AGE_WIDTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DIRECTION-1:0]           sa_request,
    input  logic [DIRECTION*DIRECTION-1:0] sa_port,
    input  logic [DIRECTION-1:0]           credit_avail,
    output logic [DIRECTION-1:0]           sa_grant,
    output logic [DIRECTION*DIRECTION-1:0] st_ctrl,
    output logic [DIRECTION-1:0]           out_unit_en,
    output logic [DIRECTION-1:0]           credit_decre,
    output logic                           req_err,
    output logic [2:0]                     rr_ptr,
    output logic                           starve_active
);

    localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(STARVE_LIMIT);

    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [AGE_WIDTH-1:0] age_q [DIRECTION];
    logic [AGE_WIDTH-1:0] age_d [DIRECTION];

    logic [DIRECTION-1:0] starving;
    logic                 s_valid;
    logic [2:0]           s_idx;
    logic [DIRECTION-1:0] reserved;
    logic [DIRECTION-1:0] claimed;
    logic [DIRECTION-1:0] grant;
    logic [DIRECTION-1:0] zero_mask;

    // A request is granted only if the whole multicast mask is credited and
    // free. Outputs reserved for the starving input are off-limits to the
    // other inputs, even when the starving input itself cannot go this cycle.
    function automatic logic can_grant(
        input logic                 req,
        input logic [DIRECTION-1:0] m,
        input logic [DIRECTION-1:0] credit,
        input logic [DIRECTION-1:0] taken,
        input logic                 is_s,
        input logic [DIRECTION-1:0] resv
    );
        can_grant = req && (m != '0) && ((m & ~credit) == '0) &&
                    ((m & taken) == '0) && (is_s || ((m & resv) == '0));
    endfunction

    always_comb begin
        starving  = '0;
        zero_mask = '0;
        for (int g = 0; g < DIRECTION; g++) begin
            starving[g]  = sa_request[g] && (age_q[g] == AGE_MAX);
            zero_mask[g] = (sa_port[g*DIRECTION +: DIRECTION] == '0);
        end

        // Descending scan leaves the lowest-index starving input selected.
        s_valid = 1'b0;
        s_idx   = '0;
        for (int g = DIRECTION - 1; g >= 0; g--) begin
            if (starving[g]) begin
                s_valid = 1'b1;
                s_idx   = 3'(g);
            end
        end
        reserved = s_valid ? sa_port[int'(s_idx)*DIRECTION +: DIRECTION] : '0;

        claimed = '0;
        grant   = '0;
        // The starving input is scanned first. The other inputs are scanned
        // afterwards in round-robin order.
        if (s_valid) begin
            if (can_grant(sa_request[s_idx], sa_port[int'(s_idx)*DIRECTION +: DIRECTION],
                          credit_avail, claimed, 1'b1, reserved)) begin
                grant[s_idx] = 1'b1;
                claimed      = claimed | sa_port[int'(s_idx)*DIRECTION +: DIRECTION];
            end
        end
        for (int k = 0; k < DIRECTION; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= DIRECTION) idx = idx - DIRECTION;
            if (!(s_valid && (idx == int'(s_idx)))) begin
                if (can_grant(sa_request[idx], sa_port[idx*DIRECTION +: DIRECTION],
                              credit_avail, claimed, 1'b0, reserved)) begin
                    grant[idx] = 1'b1;
                    claimed    = claimed | sa_port[idx*DIRECTION +: DIRECTION];
                end
            end
        end
    end

    // Pointer advances past the first non-starving grant in round-robin
    // order. The starving grant moves the pointer only when it is the
    // only grant in the cycle.
    always_comb begin
        logic found;
        int   first;
        found = 1'b0;
        first = 0;
        for (int k = 0; k < DIRECTION; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= DIRECTION) idx = idx - DIRECTION;
            if (!found && grant[idx] && !(s_valid && (idx == int'(s_idx)))) begin
                found = 1'b1;
                first = idx;
            end
        end
        if (!found && s_valid && grant[s_idx]) begin
            found = 1'b1;
            first = int'(s_idx);
        end
        if (found) begin
            rr_ptr_d = (first + 1 >= DIRECTION) ? 3'd0 : 3'(first + 1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    always_comb begin
        for (int g = 0; g < DIRECTION; g++) begin
            if (grant[g] || !sa_request[g] || zero_mask[g]) begin
                age_d[g] = '0;
            end else if (age_q[g] == AGE_MAX) begin
                age_d[g] = age_q[g];
            end else begin
                age_d[g] = age_q[g] + AGE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            for (int g = 0; g < DIRECTION; g++) age_q[g] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int g = 0; g < DIRECTION; g++) age_q[g] <= age_d[g];
        end
    end

    // Grant-path outputs are forced low while reset is held. The forcing
    // is combinational, so grants drop in the same cycle reset asserts.
    always_comb begin
        sa_grant      = '0;
        st_ctrl       = '0;
        out_unit_en   = '0;
        req_err       = 1'b0;
        starve_active = 1'b0;
        if (rst_n) begin
            sa_grant = grant;
            for (int g = 0; g < DIRECTION; g++) begin
                if (grant[g]) begin
                    st_ctrl[g*DIRECTION +: DIRECTION] = sa_port[g*DIRECTION +: DIRECTION];
                    out_unit_en = out_unit_en | sa_port[g*DIRECTION +: DIRECTION];
                end
            end
            req_err       = |(sa_request & zero_mask);
            starve_active = |starving;
        end
    end

    assign credit_decre = out_unit_en;
    assign rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_quadtree_switch_allocator.sv
// Directed bench for quadtree_switch_allocator. Inputs change 1 time unit
// after each rising edge, and outputs are sampled 2 time units later.
module tb_quadtree_switch_allocator;

  logic        clk;
  logic        rst_n;
  logic [4:0]  sa_request;
  logic [24:0] sa_port;
  logic [4:0]  credit_avail;
  logic [4:0]  sa_grant;
  logic [24:0] st_ctrl;
  logic [4:0]  out_unit_en;
  logic [4:0]  credit_decre;
  logic        req_err;
  logic [2:0]  rr_ptr;
  logic        starve_active;

  int n_checks;
  int n_fail;

  quadtree_switch_allocator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sa_request    (sa_request),
    .sa_port       (sa_port),
    .credit_avail  (credit_avail),
    .sa_grant      (sa_grant),
    .st_ctrl       (st_ctrl),
    .out_unit_en   (out_unit_en),
    .credit_decre  (credit_decre),
    .req_err       (req_err),
    .rr_ptr        (rr_ptr),
    .starve_active (starve_active)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    sa_request   = '0;
    sa_port      = '0;
    credit_avail = 5'b11111;
  endtask

  task automatic set_port(input int g, input logic [4:0] m);
    sa_port[g*5 +: 5] = m;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [4:0] exp_g;
  logic [2:0] exp_rr;
  logic       exp_sa;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    tick();

    // Reset with all inputs requesting output 0: outputs are held low.
    sa_request = 5'b11111;
    for (int g = 0; g < 5; g++) set_port(g, 5'b00001);
    for (int c = 0; c < 3; c++) begin
      settle();
      check("rst_grant", 32'(sa_grant), 32'h0);
      check("rst_st_ctrl", 32'(st_ctrl), 32'h0);
      check("rst_out_en", 32'(out_unit_en), 32'h0);
      check("rst_credit_decre", 32'(credit_decre), 32'h0);
      check("rst_req_err", 32'(req_err), 32'h0);
      check("rst_starve", 32'(starve_active), 32'h0);
      tick();
    end
    rst_n = 1'b1;
    settle();
    check("rel_rr_ptr", 32'(rr_ptr), 32'd0);
    check("rel_grant", 32'(sa_grant), 32'h01);
    check("rel_st_ctrl", 32'(st_ctrl), 32'h1);
    tick();
    settle();
    check("rel_rr_next", 32'(rr_ptr), 32'd1);

    // Unicast contention: inputs 0, 1 and 2 all request output 0.
    do_reset();
    sa_request = 5'b00111;
    for (int g = 0; g < 3; g++) set_port(g, 5'b00001);
    for (int c = 0; c < 6; c++) begin
      exp_g = 5'b00001 << (c % 3);
      settle();
      check("uni_grant", 32'(sa_grant), 32'(exp_g));
      check("uni_credit_decre", 32'(credit_decre), 32'h01);
      tick();
    end

    // Parallel disjoint grants.
    do_reset();
    sa_request = 5'b10101;
    set_port(0, 5'b00010);
    set_port(2, 5'b00100);
    set_port(4, 5'b01000);
    settle();
    check("par_grant", 32'(sa_grant), 32'h15);
    check("par_out_en", 32'(out_unit_en), 32'h0e);
    check("par_credit_decre", 32'(credit_decre), 32'h0e);
    check("par_st_ctrl", 32'(st_ctrl),
          32'({5'b01000, 5'b00000, 5'b00100, 5'b00000, 5'b00010}));
    tick();
    settle();
    check("par_rr_ptr", 32'(rr_ptr), 32'd1);

    // Multicast credit gate: input 4 waits for all four credits.
    do_reset();
    sa_request   = 5'b10000;
    set_port(4, 5'b01111);
    credit_avail = 5'b11101;
    settle();
    check("mc_nogrant", 32'(sa_grant), 32'h0);
    check("mc_out_en_zero", 32'(out_unit_en), 32'h0);
    tick();
    credit_avail = 5'b11111;
    settle();
    check("mc_grant", 32'(sa_grant), 32'h10);
    check("mc_st_ctrl", 32'(st_ctrl), 32'({5'b01111, 20'h0}));
    tick();
    settle();
    check("mc_rr_wrap", 32'(rr_ptr), 32'd0);

    // Starvation reservation.
    do_reset();
    sa_request = 5'b10001;
    set_port(4, 5'b01111);
    set_port(0, 5'b00001);
    for (int c = 0; c < 22; c++) begin
      credit_avail = (c >= 20) ? 5'b11111 : 5'b11101;
      if (c < 15)       exp_g = 5'b00001;
      else if (c < 20)  exp_g = 5'b00000;
      else if (c == 20) exp_g = 5'b10000;
      else              exp_g = 5'b00001;
      exp_sa = (c >= 15) && (c <= 20);
      exp_rr = (c == 0 || c == 21) ? 3'd0 : 3'd1;
      settle();
      check($sformatf("stv_grant_c%0d", c), 32'(sa_grant), 32'(exp_g));
      check($sformatf("stv_active_c%0d", c), 32'(starve_active), 32'(exp_sa));
      check($sformatf("stv_rr_c%0d", c), 32'(rr_ptr), 32'(exp_rr));
      if (c == 20) begin
        check("stv_st_ctrl", 32'(st_ctrl), 32'({5'b01111, 20'h0}));
        check("stv_credit_decre", 32'(credit_decre), 32'h0f);
      end
      tick();
    end

    // Zero mask: input 3 is never granted and never ages into starvation.
    do_reset();
    sa_request = 5'b01001;
    set_port(0, 5'b00010);
    set_port(3, 5'b00000);
    for (int c = 0; c < 18; c++) begin
      settle();
      check("zm_req_err", 32'(req_err), 32'h1);
      check("zm_grant", 32'(sa_grant), 32'h01);
      check("zm_starve", 32'(starve_active), 32'h0);
      tick();
    end
    check("zm_out_en", 32'(out_unit_en), 32'h02);
    set_port(3, 5'b00100);
    settle();
    check("zm_cleared_err", 32'(req_err), 32'h0);
    check("zm_both_grant", 32'(sa_grant), 32'h09);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
